// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlc_pkg
// Purpose  : Shared definitions for the traffic-light controller: FSM state
//            encoding, lamp bit positions inside one approach's 3-bit lamp
//            group, and the active-low 7-segment decoder.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package tlc_pkg;

    // FSM state encoding
    localparam int              c_state_w = 3;
    localparam logic [2:0]      ALL_RED   = 3'd0;
    localparam logic [2:0]      GREEN     = 3'd1;
    localparam logic [2:0]      YELLOW    = 3'd2;
    localparam logic [2:0]      WALK      = 3'd3;
    localparam logic [2:0]      FLASH     = 3'd4;

    // Bit positions within one approach's lamp group
    localparam int              c_lamp_green  = 0;
    localparam int              c_lamp_yellow = 1;
    localparam int              c_lamp_red    = 2;
    localparam int              c_lamp_grp_w  = 3;

    // Active-low segment pattern with every segment off
    localparam logic [6:0]      c_seg_blank = 7'h7F;

    // Active-low 7-segment decoder, bit 0 = segment a ... bit 6 = segment g.
    // Codes above 9 render blank.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = c_seg_blank;
        endcase
        return seg;
    endfunction

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/traffic_light_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running divider producing a one-clock-wide enable every DIV
//            clocks. The first enable is consumed on the DIV-th rising edge
//            after reset release, i.e. one full tick period later.
// Ports    : clk    - board clock
//            rst    - asynchronous reset, active-high
//            o_tick - one-cycle tick enable
// Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int                 c_cnt_w = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule : tick_gen
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Purpose  : N-approach round-robin traffic-light controller with a
//            pedestrian walk phase, night flash mode and a 7-segment
//            countdown. Everything runs on the board clock; timing is
//            counted in ticks from an internal enable.
// Ports    : clk         - board clock
//            rst         - asynchronous reset, active-high
//            ped_btn     - pedestrian button, asynchronous, synchronised here
//            night       - level, requests flash mode at the next all-red exit
//            green_ext   - level, doubles green length, sampled at GREEN entry
//            lamps       - per approach i: [3i+2]=red [3i+1]=yellow [3i]=green
//            ped_walk    - walk lamp
//            ped_pending - latched pedestrian request awaiting service
//            HEX2        - phase index digit (active-low)
//            HEX1, HEX0  - countdown tens/ones, leading zero blanked
// Revision : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int N_APPROACH = 2,
    parameter int GREEN_T    = 10,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 2,
    parameter int WALK_T     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ped_btn,
    input  logic                    night,
    input  logic                    green_ext,
    output logic [3*N_APPROACH-1:0] lamps,
    output logic                    ped_walk,
    output logic                    ped_pending,
    output logic [6:0]              HEX2,
    output logic [6:0]              HEX1,
    output logic [6:0]              HEX0
);

    // ------------------------------------------------------------------
    // Parameter range checks, evaluated at elaboration
    // ------------------------------------------------------------------
    if (TICK_HZ < 1 || (CLK_FREQ % TICK_HZ) != 0 || (CLK_FREQ / TICK_HZ) < 2) begin : g_bad_div
        $error("traffic_light_ctrl: CLK_FREQ/TICK_HZ must be an integer >= 2");
    end
    if (N_APPROACH < 2 || N_APPROACH > 4) begin : g_bad_napp
        $error("traffic_light_ctrl: N_APPROACH must be 2..4");
    end
    if (GREEN_T < 1 || GREEN_T > 99) begin : g_bad_green
        $error("traffic_light_ctrl: GREEN_T must be 1..99");
    end
    if (YELLOW_T < 1 || YELLOW_T > 99) begin : g_bad_yellow
        $error("traffic_light_ctrl: YELLOW_T must be 1..99");
    end
    if (ALLRED_T < 1 || ALLRED_T > 99) begin : g_bad_allred
        $error("traffic_light_ctrl: ALLRED_T must be 1..99");
    end
    if (WALK_T < 1 || WALK_T > 99) begin : g_bad_walk
        $error("traffic_light_ctrl: WALK_T must be 1..99");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                   c_div     = CLK_FREQ / TICK_HZ;
    localparam int                   c_cd_w    = 8;   // holds up to 2*99
    localparam int                   c_p_w     = (N_APPROACH > 2) ? $clog2(N_APPROACH) : 1;
    localparam logic [c_p_w-1:0]     c_p_last  = c_p_w'(N_APPROACH - 1);

    localparam logic [c_cd_w-1:0]    c_cd_green     = c_cd_w'(GREEN_T);
    localparam logic [c_cd_w-1:0]    c_cd_green_ext = c_cd_w'(2 * GREEN_T);
    localparam logic [c_cd_w-1:0]    c_cd_yellow    = c_cd_w'(YELLOW_T);
    localparam logic [c_cd_w-1:0]    c_cd_allred    = c_cd_w'(ALLRED_T);
    localparam logic [c_cd_w-1:0]    c_cd_walk      = c_cd_w'(WALK_T);

    localparam logic [3*N_APPROACH-1:0] c_lamps_all_red = {N_APPROACH{3'b100}};

    // Reset image of the registered display: phase 0, countdown ALLRED_T
    localparam logic [6:0] c_hex2_rst = seg7(4'd0);
    localparam logic [6:0] c_hex1_rst = ((ALLRED_T / 10) == 0) ? c_seg_blank
                                                              : seg7(4'((ALLRED_T / 10) % 10));
    localparam logic [6:0] c_hex0_rst = seg7(4'(ALLRED_T % 10));

    // ------------------------------------------------------------------
    // Tick enable
    // ------------------------------------------------------------------
    logic w_tick;

    tick_gen #(
        .DIV    (c_div)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Pedestrian button: two-flop synchroniser plus rising-edge detect.
    // A held button therefore registers as a single request.
    // ------------------------------------------------------------------
    logic r_ped_meta;
    logic r_ped_sync;
    logic r_ped_prev;
    logic w_ped_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_meta <= 1'b0;
            r_ped_sync <= 1'b0;
            r_ped_prev <= 1'b0;
        end else begin
            r_ped_meta <= ped_btn;
            r_ped_sync <= r_ped_meta;
            r_ped_prev <= r_ped_sync;
        end
    end

    assign w_ped_rise = r_ped_sync & ~r_ped_prev;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [c_cd_w-1:0]    r_cd;
    logic [c_cd_w-1:0]    w_cd_nxt;
    logic [c_p_w-1:0]     r_phase;
    logic [c_p_w-1:0]     w_phase_nxt;
    logic                 r_flash_lit;
    logic                 w_flash_lit_nxt;
    logic                 r_ped_pending;
    logic                 w_pending_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ALL_RED;
            r_cd          <= c_cd_allred;
            r_phase       <= '0;
            r_flash_lit   <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cd          <= w_cd_nxt;
            r_phase       <= w_phase_nxt;
            r_flash_lit   <= w_flash_lit_nxt;
            r_ped_pending <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Every timed state is left on the tick that
    // finds the countdown at 1, so a state loaded with D lasts D ticks.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cd_nxt        = r_cd;
        w_phase_nxt     = r_phase;
        w_flash_lit_nxt = r_flash_lit;

        if (w_tick) begin
            if (r_state == FLASH) begin
                // Flash has no duration; it ends on the first tick without night
                if (!night) begin
                    w_state_nxt = ALL_RED;
                    w_cd_nxt    = c_cd_allred;
                    w_phase_nxt = '0;
                end else begin
                    w_flash_lit_nxt = ~r_flash_lit;
                end
            end else if (r_cd <= 8'd1) begin
                case (r_state)
                    ALL_RED: begin
                        if (night) begin
                            w_state_nxt     = FLASH;
                            w_cd_nxt        = '0;
                            w_flash_lit_nxt = 1'b1;
                        end else if (r_ped_pending) begin
                            w_state_nxt = WALK;
                            w_cd_nxt    = c_cd_walk;
                        end else begin
                            w_state_nxt = GREEN;
                            w_cd_nxt    = green_ext ? c_cd_green_ext : c_cd_green;
                        end
                    end
                    GREEN: begin
                        w_state_nxt = YELLOW;
                        w_cd_nxt    = c_cd_yellow;
                    end
                    YELLOW: begin
                        w_state_nxt = ALL_RED;
                        w_cd_nxt    = c_cd_allred;
                        w_phase_nxt = (r_phase == c_p_last) ? '0 : r_phase + 1'b1;
                    end
                    WALK: begin
                        w_state_nxt = ALL_RED;
                        w_cd_nxt    = c_cd_allred;
                    end
                    default: begin
                        // Unreachable encodings recover to a safe all-red
                        w_state_nxt = ALL_RED;
                        w_cd_nxt    = c_cd_allred;
                        w_phase_nxt = '0;
                    end
                endcase
            end else begin
                w_cd_nxt = r_cd - 1'b1;
            end
        end

        // Request latch: presses during WALK are ignored, and entering WALK
        // consumes the request even if a press lands on the same cycle.
        w_pending_nxt = r_ped_pending;
        if (w_ped_rise && (r_state != WALK)) begin
            w_pending_nxt = 1'b1;
        end
        if ((w_state_nxt == WALK) && (r_state != WALK)) begin
            w_pending_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered below)
    // ------------------------------------------------------------------
    logic [3*N_APPROACH-1:0] w_lamps;
    logic                    w_ped_walk;
    logic [3:0]              w_tens;
    logic [3:0]              w_ones;
    logic [6:0]              w_hex2;
    logic [6:0]              w_hex1;
    logic [6:0]              w_hex0;

    always_comb begin
        w_lamps    = '0;
        w_ped_walk = (r_state == WALK);

        for (int i = 0; i < N_APPROACH; i++) begin
            if (r_state == FLASH) begin
                w_lamps[c_lamp_grp_w*i + c_lamp_yellow] = r_flash_lit;
            end else if ((r_state == GREEN) && (int'(r_phase) == i)) begin
                w_lamps[c_lamp_grp_w*i + c_lamp_green] = 1'b1;
            end else if ((r_state == YELLOW) && (int'(r_phase) == i)) begin
                w_lamps[c_lamp_grp_w*i + c_lamp_yellow] = 1'b1;
            end else begin
                w_lamps[c_lamp_grp_w*i + c_lamp_red] = 1'b1;
            end
        end

        // Countdown never exceeds 198; the display carries only the low two
        // decimal digits.
        w_tens = 4'((r_cd / 8'd10) % 8'd10);
        w_ones = 4'(r_cd % 8'd10);

        w_hex2 = seg7(4'(r_phase));
        if (r_state == FLASH) begin
            w_hex1 = c_seg_blank;
            w_hex0 = c_seg_blank;
        end else begin
            w_hex1 = (w_tens == 4'd0) ? c_seg_blank : seg7(w_tens);
            w_hex0 = seg7(w_ones);
        end
    end

    // Output register; reset drives outputs straight to their reset image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamps    <= c_lamps_all_red;
            ped_walk <= 1'b0;
            HEX2     <= c_hex2_rst;
            HEX1     <= c_hex1_rst;
            HEX0     <= c_hex0_rst;
        end else begin
            lamps    <= w_lamps;
            ped_walk <= w_ped_walk;
            HEX2     <= w_hex2;
            HEX1     <= w_hex1;
            HEX0     <= w_hex0;
        end
    end

    assign ped_pending = r_ped_pending;

endmodule : traffic_light_ctrl
`default_nettype wire
